// File: rtl/conversion_sequencer.sv
// -----------------------------------------------------------------------------
// conversion_sequencer
//
// Initiator side of the cycle-counter interface in the voltmeter back-end.
// One start request runs a full conversion: the comparator is sampled for
// SAMPLES_PER_CYCLE clocks, then the external cycle counter is advanced with
// a single increment pulse, and the counter value is checked against an
// internal shadow index. This repeats until the counter reports terminal
// count. The comparator-ones total is then offered downstream with a
// valid/ready handshake. Any disagreement with the counter aborts the
// conversion with a one-clock err_o pulse.
//
// Ports:
//   clk_i           system clock
//   rst_n_i         asynchronous active-low reset
//   start_i         conversion request, only honoured in IDLE
//   comp_i          synchronised comparator output
//   stop_i          terminal-count flag from the cycle counter
//   cycle_count_i   current count from the cycle counter
//   increment_o     one-clock increment pulse to the cycle counter
//   busy_o          conversion in progress (SAMPLE/ADVANCE/CHECK)
//   result_o        accumulated comparator-ones count
//   result_valid_o  result available, held until accepted
//   result_ready_i  downstream accepts the result
//   err_o           one-clock pulse on a desynchronisation abort
// -----------------------------------------------------------------------------
module conversion_sequencer #(
    parameter int SAMPLES_PER_CYCLE = 16,
    parameter int NUM_CYCLES        = 24,
    parameter int RESULT_W          = 10
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    input  logic                comp_i,
    input  logic                stop_i,
    input  logic [4:0]          cycle_count_i,
    output logic                increment_o,
    output logic                busy_o,
    output logic [RESULT_W-1:0] result_o,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic                err_o
);

    localparam logic [5:0] LAST_SAMPLE = 6'(SAMPLES_PER_CYCLE - 1);
    localparam logic [4:0] TERMINAL    = 5'(NUM_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        ADVANCE,
        CHECK,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [RESULT_W-1:0] acc_q, acc_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic [5:0]          sample_cnt_q, sample_cnt_d;
    logic [4:0]          shadow_q, shadow_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            result_q     <= '0;
            sample_cnt_q <= '0;
            shadow_q     <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            result_q     <= result_d;
            sample_cnt_q <= sample_cnt_d;
            shadow_q     <= shadow_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        result_d     = result_q;
        sample_cnt_d = sample_cnt_q;
        shadow_d     = shadow_q;
        valid_d      = valid_q;
        err_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The counter must be parked at zero before a conversion may
                // begin, otherwise both sides would disagree from the outset.
                if (start_i) begin
                    if (!stop_i && (cycle_count_i == 5'd0)) begin
                        state_d      = SAMPLE;
                        acc_d        = '0;
                        sample_cnt_d = '0;
                        shadow_d     = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SAMPLE: begin
                acc_d        = acc_q + {{(RESULT_W-1){1'b0}}, comp_i};
                sample_cnt_d = sample_cnt_q + 6'd1;
                if (sample_cnt_q == LAST_SAMPLE) begin
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                shadow_d = shadow_q + 5'd1;
                state_d  = CHECK;
            end
            CHECK: begin
                // The counter has seen the increment by now, so its value and
                // the shadow index must agree; stop_i is only legitimate when
                // the shadow index has reached terminal count.
                if (cycle_count_i != shadow_q) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (stop_i && (shadow_q == TERMINAL)) begin
                    result_d = acc_q;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else if (stop_i) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    sample_cnt_d = '0;
                    state_d      = SAMPLE;
                end
            end
            DONE: begin
                if (valid_q && result_ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ADVANCE lasts a single clock and is always followed by CHECK, so the
    // increment pulse can never stretch over two clocks.
    assign increment_o    = (state_q == ADVANCE) && !stop_i;
    assign busy_o         = (state_q == SAMPLE) || (state_q == ADVANCE) || (state_q == CHECK);
    assign result_o       = result_q;
    assign result_valid_o = valid_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_conversion_sequencer.sv
// -----------------------------------------------------------------------------
// tb_conversion_sequencer
//
// Drives conversion_sequencer against a behavioural model of the external
// cycle counter (increments on increment_o, flags stop at 24, self-clears a
// clock later, can be told to drop one increment or be preloaded). Expected
// results are pushed to a queue when a conversion is started and popped when
// the DUT presents result_valid_o.
// -----------------------------------------------------------------------------
module tb_conversion_sequencer;

    localparam int SPC    = 16;
    localparam int NCYC   = 24;
    localparam int RW     = 10;
    localparam int PERIOD = SPC + 2;

    logic          clk_i;
    logic          rst_n_i;
    logic          start_i;
    logic          comp_i;
    logic          stop_i;
    logic [4:0]    cycle_count_i;
    logic          increment_o;
    logic          busy_o;
    logic [RW-1:0] result_o;
    logic          result_valid_o;
    logic          result_ready_i;
    logic          err_o;

    int vectors    = 0;
    int miscompares = 0;

    int compMode   = 0;
    int skipAt     = 0;
    int incSeen    = 0;
    logic       cntLoad    = 1'b0;
    logic [4:0] cntLoadVal = 5'd0;

    int expQ[$];

    conversion_sequencer #(
        .SAMPLES_PER_CYCLE(SPC),
        .NUM_CYCLES       (NCYC),
        .RESULT_W         (RW)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .start_i       (start_i),
        .comp_i        (comp_i),
        .stop_i        (stop_i),
        .cycle_count_i (cycle_count_i),
        .increment_o   (increment_o),
        .busy_o        (busy_o),
        .result_o      (result_o),
        .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i),
        .err_o         (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Comparator stimulus changes on the falling edge, away from sampling.
    initial comp_i = 1'b0;
    always @(negedge clk_i) begin
        case (compMode)
            1:       comp_i = 1'b1;
            2:       comp_i = ~comp_i;
            default: comp_i = 1'b0;
        endcase
    end

    // Cycle counter model sharing the DUT reset.
    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cycle_count_i <= 5'd0;
            incSeen       <= 0;
        end else if (cntLoad) begin
            cycle_count_i <= cntLoadVal;
        end else if (cycle_count_i == 5'(NCYC)) begin
            cycle_count_i <= 5'd0;
            incSeen       <= 0;
        end else if (increment_o) begin
            incSeen <= incSeen + 1;
            if (skipAt != incSeen + 1) cycle_count_i <= cycle_count_i + 5'd1;
        end
    end
    assign stop_i = (cycle_count_i == 5'(NCYC));

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Start is accepted at the edge inside this task; that edge is edge 0.
    task automatic startPulse();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Follows a conversion from edge 0 until result_valid_o rises, gathering
    // observations for the calling test to judge.
    task automatic runConversion(output int validEdge, output int incPulses,
                                 output int spacingErr, output int errPulses,
                                 output logic busyAtValid);
        int lastInc;
        lastInc     = -1;
        validEdge   = -1;
        incPulses   = 0;
        spacingErr  = 0;
        errPulses   = 0;
        busyAtValid = 1'b1;
        for (int k = 1; k <= 600; k++) begin
            tick();
            if (increment_o) begin
                if (stop_i) spacingErr++;
                if (lastInc >= 0 && (k - lastInc) != PERIOD) spacingErr++;
                if (lastInc < 0 && k != SPC) spacingErr++;
                lastInc = k;
                incPulses++;
            end
            if (err_o) errPulses++;
            if (result_valid_o) begin
                validEdge   = k;
                busyAtValid = busy_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n_i        = 1'b0;
        start_i        = 1'b0;
        result_ready_i = 1'b1;
        #2;
        vectors++;
        if ({increment_o, busy_o, result_valid_o, err_o} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags got %b want 0000", {increment_o, busy_o, result_valid_o, err_o});
        end
        vectors++;
        if (result_o !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_result got %0d want 0", result_o);
        end
        tick();
        tick();
        rst_n_i = 1'b1;
        tick();
        vectors++;
        if (busy_o !== 1'b0 || stop_i !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_idle busy=%b stop=%b want 0 0", busy_o, stop_i);
        end
    endtask

    // Shared body for the plain constant/toggle conversions.
    task automatic test_conversion(input int mode, input int expected, input string name);
        int vEdge, nInc, spErr, nErr;
        logic busyV;
        int got;
        compMode = mode;
        tick();
        startPulse();
        expQ.push_back(expected);
        runConversion(vEdge, nInc, spErr, nErr, busyV);
        vectors++;
        if (vEdge != NCYC * PERIOD) begin
            miscompares++;
            $display("[TB] FAIL %s_valid_edge got %0d want %0d", name, vEdge, NCYC * PERIOD);
        end
        vectors++;
        if (nInc != NCYC || spErr != 0) begin
            miscompares++;
            $display("[TB] FAIL %s_increments got %0d pulses %0d spacing errors want %0d 0", name, nInc, spErr, NCYC);
        end
        vectors++;
        if (busyV !== 1'b0 || nErr != 0) begin
            miscompares++;
            $display("[TB] FAIL %s_busy_err got busy=%b err=%0d want 0 0", name, busyV, nErr);
        end
        got = (expQ.size() > 0) ? expQ.pop_front() : -1;
        vectors++;
        if (result_o !== RW'(got) || got < 0) begin
            miscompares++;
            $display("[TB] FAIL %s_result got %0d want %0d", name, result_o, got);
        end
        tick();
        vectors++;
        if (result_valid_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s_handshake got valid=%b want 0", name, result_valid_o);
        end
    endtask

    task automatic test_backpressure();
        int vEdge, nInc, spErr, nErr;
        logic busyV;
        int got, held, unstable;
        compMode       = 2;
        result_ready_i = 1'b0;
        tick();
        startPulse();
        expQ.push_back(192);
        runConversion(vEdge, nInc, spErr, nErr, busyV);
        got = (expQ.size() > 0) ? expQ.pop_front() : -1;
        vectors++;
        if (vEdge != NCYC * PERIOD || result_o !== RW'(got)) begin
            miscompares++;
            $display("[TB] FAIL bp_first got edge=%0d result=%0d want %0d %0d", vEdge, result_o, NCYC * PERIOD, got);
        end
        held     = got;
        unstable = 0;
        start_i  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (result_o !== RW'(held) || result_valid_o !== 1'b1 || busy_o !== 1'b0 || increment_o !== 1'b0)
                unstable++;
        end
        vectors++;
        if (unstable != 0) begin
            miscompares++;
            $display("[TB] FAIL bp_hold got %0d unstable clocks want 0", unstable);
        end
        result_ready_i = 1'b1;
        tick();
        vectors++;
        if (result_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_release got valid=%b busy=%b want 0 0", result_valid_o, busy_o);
        end
        tick();
        start_i = 1'b0;
        vectors++;
        if (busy_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_restart got busy=%b want 1", busy_o);
        end
        expQ.push_back(192);
        runConversion(vEdge, nInc, spErr, nErr, busyV);
        got = (expQ.size() > 0) ? expQ.pop_front() : -1;
        vectors++;
        if (vEdge != NCYC * PERIOD || result_o !== RW'(got) || nInc != NCYC) begin
            miscompares++;
            $display("[TB] FAIL bp_second got edge=%0d result=%0d inc=%0d want %0d %0d %0d",
                     vEdge, result_o, nInc, NCYC * PERIOD, got, NCYC);
        end
        tick();
    endtask

    task automatic test_async_reset();
        int vEdge, nInc, spErr, nErr;
        logic busyV;
        int got;
        compMode = 1;
        tick();
        startPulse();
        for (int k = 1; k <= 9 * PERIOD + 8; k++) tick();
        #2;
        rst_n_i = 1'b0;
        #1;
        vectors++;
        if ({increment_o, busy_o, result_valid_o, err_o} !== 4'b0000 || result_o !== '0) begin
            miscompares++;
            $display("[TB] FAIL async_reset got flags=%b result=%0d want 0000 0",
                     {increment_o, busy_o, result_valid_o, err_o}, result_o);
        end
        tick();
        rst_n_i = 1'b1;
        tick();
        vectors++;
        if (err_o !== 1'b0 || cycle_count_i !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_release got err=%b count=%0d want 0 0", err_o, cycle_count_i);
        end
        startPulse();
        expQ.push_back(NCYC * SPC);
        runConversion(vEdge, nInc, spErr, nErr, busyV);
        got = (expQ.size() > 0) ? expQ.pop_front() : -1;
        vectors++;
        if (vEdge != NCYC * PERIOD || result_o !== RW'(got) || nErr != 0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_rerun got edge=%0d result=%0d err=%0d want %0d %0d 0",
                     vEdge, result_o, nErr, NCYC * PERIOD, got);
        end
        tick();
    endtask

    task automatic test_faulty_counter();
        int errEdge, errCount, validSeen;
        logic busyAtErr;
        compMode  = 1;
        skipAt    = 5;
        errEdge   = -1;
        errCount  = 0;
        validSeen = 0;
        busyAtErr = 1'b1;
        tick();
        startPulse();
        for (int k = 1; k <= 150; k++) begin
            tick();
            if (err_o) begin
                errCount++;
                if (errEdge < 0) begin
                    errEdge   = k;
                    busyAtErr = busy_o;
                end
            end
            if (result_valid_o) validSeen++;
        end
        vectors++;
        if (errEdge != 5 * PERIOD || errCount != 1) begin
            miscompares++;
            $display("[TB] FAIL fault_err got edge=%0d pulses=%0d want %0d 1", errEdge, errCount, 5 * PERIOD);
        end
        vectors++;
        if (busyAtErr !== 1'b0 || validSeen != 0 || busy_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL fault_idle got busy=%b valid_clocks=%0d want 0 0", busyAtErr, validSeen);
        end
        skipAt  = 0;
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_bad_start();
        int errCount, incCount, busyCount;
        cntLoadVal = 5'd3;
        cntLoad    = 1'b1;
        tick();
        cntLoad = 1'b0;
        startPulse();
        errCount  = err_o ? 1 : 0;
        incCount  = 0;
        busyCount = busy_o ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (err_o) errCount++;
            if (increment_o) incCount++;
            if (busy_o) busyCount++;
        end
        vectors++;
        if (errCount != 1) begin
            miscompares++;
            $display("[TB] FAIL bad_start_err got %0d pulses want 1", errCount);
        end
        vectors++;
        if (incCount != 0 || busyCount != 0) begin
            miscompares++;
            $display("[TB] FAIL bad_start_quiet got inc=%0d busy=%0d want 0 0", incCount, busyCount);
        end
        cntLoadVal = 5'd0;
        cntLoad    = 1'b1;
        tick();
        cntLoad = 1'b0;
    endtask

    initial begin
        test_reset();
        test_conversion(1, NCYC * SPC, "ones");
        test_conversion(0, 0, "zeros");
        test_conversion(2, NCYC * SPC / 2, "toggle");
        test_backpressure();
        test_async_reset();
        test_faulty_counter();
        test_bad_start();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
